// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with Z/V/N flags, sticky halt and retire counter.
// Priority per edge: flush > stall > normal; a halted stage drains bubbles until reset.
module ex_mem_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_zero,
    input  logic              ex_ovfl,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_halt,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_halt,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_W-1:0]  r_rd;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_halt;
    logic              r_z;
    logic              r_v;
    logic              r_n;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cnt;

    logic w_bubble;
    logic w_capture;
    logic w_upd_z;
    logic w_upd_vn;

    // Adder ops own all three flags; logic/shift ops only report zero.
    always_comb begin
        w_upd_z  = 1'b0;
        w_upd_vn = 1'b0;
        case (ex_opcode)
            OP_ADD, OP_SUB: begin
                w_upd_z  = 1'b1;
                w_upd_vn = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_upd_z = 1'b1;
            default: ;
        endcase
    end

    assign w_bubble  = flush || (!stall && r_halted);
    assign w_capture = !flush && !stall && !r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_halt       <= 1'b0;
            r_z          <= 1'b0;
            r_v          <= 1'b0;
            r_n          <= 1'b0;
            r_halted     <= 1'b0;
            r_cnt        <= '0;
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_halt       <= 1'b0;
        end else if (w_capture) begin
            r_valid      <= ex_valid;
            r_result     <= ex_result;
            r_store_data <= ex_store_data;
            r_rd         <= ex_rd;
            r_reg_write  <= ex_reg_write && ex_valid;
            r_mem_read   <= ex_mem_read && ex_valid;
            r_mem_write  <= ex_mem_write && ex_valid;
            r_halt       <= ex_halt && ex_valid;
            if (ex_valid) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_upd_z)
                    r_z <= ex_zero;
                if (w_upd_vn) begin
                    r_v <= ex_ovfl;
                    r_n <= ex_result[DATA_W-1];
                end
                if (ex_halt)
                    r_halted <= 1'b1;
            end
        end
    end

    assign mem_valid      = r_valid;
    assign mem_result     = r_result;
    assign mem_store_data = r_store_data;
    assign mem_rd         = r_rd;
    assign mem_reg_write  = r_reg_write;
    assign mem_mem_read   = r_mem_read;
    assign mem_mem_write  = r_mem_write;
    assign mem_halt       = r_halt;
    assign flag_z         = r_z;
    assign flag_v         = r_v;
    assign flag_n         = r_n;
    assign halted         = r_halted;
    assign retired_cnt    = r_cnt;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - randomized bench for ex_mem_stage against a behavioural model.
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, ex_valid = 1'b0;
    logic [3:0]  ex_opcode = '0;
    logic [15:0] ex_result = '0, ex_store_data = '0;
    logic        ex_zero = 1'b0, ex_ovfl = 1'b0;
    logic [3:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_halt = 1'b0;

    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt;
    logic [15:0] mem_result, mem_store_data, retired_cnt;
    logic [3:0]  mem_rd;
    logic        flag_z, flag_v, flag_n, halted;

    ex_mem_stage #(.DATA_W(16), .REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_zero(ex_zero), .ex_ovfl(ex_ovfl), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_halt(ex_halt),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_halt(mem_halt),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
        .halted(halted), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the architecturally visible state.
    logic        m_valid, m_rw, m_mr, m_mw, m_halt, m_z, m_v, m_n, m_halted;
    logic [15:0] m_result, m_sd;
    logic [3:0]  m_rd;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_stage();
        m_valid = 0; m_result = 0; m_sd = 0; m_rd = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_halt = 0;
    endtask

    task automatic model_reset();
        model_clear_stage();
        m_z = 0; m_v = 0; m_n = 0; m_halted = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        if (flush || (!stall && m_halted)) begin
            model_clear_stage();
        end else if (!stall) begin
            m_valid  = ex_valid;
            m_result = ex_result;
            m_sd     = ex_store_data;
            m_rd     = ex_rd;
            m_rw     = ex_reg_write & ex_valid;
            m_mr     = ex_mem_read & ex_valid;
            m_mw     = ex_mem_write & ex_valid;
            m_halt   = ex_halt & ex_valid;
            if (ex_valid) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (ex_opcode == 4'd0 || ex_opcode == 4'd1) begin
                    m_z = ex_zero; m_v = ex_ovfl; m_n = ex_result[15];
                end else if (ex_opcode inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
                    m_z = ex_zero;
                end
                if (ex_halt) m_halted = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic z, input logic ov, input logic rw, input logic mr,
                         input logic h);
        ex_valid = v; ex_opcode = op; ex_result = res; ex_zero = z; ex_ovfl = ov;
        ex_store_data = res ^ 16'h5A5A; ex_rd = res[3:0] ^ op;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = ~rw & ~mr & v; ex_halt = h;
    endtask

    // Compare process: every falling edge while out of reset.
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("mem_valid", {31'd0, mem_valid}, {31'd0, m_valid});
            chk("mem_result", {16'd0, mem_result}, {16'd0, m_result});
            chk("mem_store_data", {16'd0, mem_store_data}, {16'd0, m_sd});
            chk("mem_rd", {28'd0, mem_rd}, {28'd0, m_rd});
            chk("mem_ctrl", {28'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt},
                {28'd0, m_rw, m_mr, m_mw, m_halt});
            chk("flags", {29'd0, flag_z, flag_v, flag_n}, {29'd0, m_z, m_v, m_n});
            chk("halted", {31'd0, halted}, {31'd0, m_halted});
            chk("retired_cnt", {16'd0, retired_cnt}, m_cnt[15:0]);
        end
    end

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        chk_en = 1;
        // Reset mid-run
        drive(1, 4'd0, 16'h1111, 0, 0, 1, 0, 0); tick();
        drive(1, 4'd0, 16'h2222, 0, 0, 1, 0, 0); tick();
        #2 rst_n = 1'b0; model_reset();
        #1;
        chk("async_reset_out", {mem_valid, mem_result, retired_cnt, flag_z, flag_v, flag_n, halted},
            33'd0);
        chk("async_reset_ctrl", {28'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        drive(1, 4'd0, 16'h0005, 0, 0, 1, 0, 0); tick();
        chk("first_add", {mem_valid, mem_result, retired_cnt}, {1'b1, 16'h0005, 16'd1});
        // Flags
        drive(1, 4'd1, 16'h8000, 0, 1, 1, 0, 0); tick();
        chk("sub_flags", {29'd0, flag_z, flag_v, flag_n}, 32'b011);
        drive(1, 4'd4, 16'h0000, 1, 0, 1, 0, 0); tick();
        chk("sll_flags", {29'd0, flag_z, flag_v, flag_n}, 32'b111);
        drive(1, 4'd8, 16'h0000, 0, 0, 1, 1, 0); tick();
        chk("lw_flags", {29'd0, flag_z, flag_v, flag_n}, 32'b111);
        // Stall / flush
        drive(1, 4'd2, 16'h1234, 0, 0, 1, 0, 0); tick();
        chk("xor_capture", {retired_cnt, mem_result, 2'd0, flag_z, flag_v, flag_n},
            {16'd5, 16'h1234, 5'b00011});
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd0, 16'hBEEF + 16'(i), 1, 1, 0, 1, 0); tick();
        end
        chk("stall_hold", {retired_cnt, mem_result, 3'd0, mem_valid}, {16'd5, 16'h1234, 4'd1});
        flush = 1; tick();
        chk("stall_flush", {28'd0, mem_valid, mem_reg_write, flag_z, flag_v}, 32'b0001);
        stall = 0; flush = 0;
        // Invalid gating
        drive(0, 4'd0, 16'h0000, 1, 0, 1, 0, 0); tick();
        chk("invalid_gate", {retired_cnt, 13'd0, mem_valid, mem_reg_write, flag_z},
            {16'd5, 16'd0});
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 0);
            tick();
        end
        stall = 0; flush = 0;
        // Counter wrap
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        drive(1, 4'd7, 16'h0001, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65535; i++) tick();
        chk("cnt_full", {16'd0, retired_cnt}, 32'h0000FFFF);
        tick();
        chk("cnt_wrap", {16'd0, retired_cnt}, 32'd0);
        // Halt
        drive(1, 4'hF, 16'h0000, 0, 0, 0, 0, 1); tick();
        chk("halt_set", {30'd0, halted, mem_halt}, 32'b11);
        drive(1, 4'd0, 16'h0000, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("halt_drain", {retired_cnt, 13'd0, mem_valid, flag_z, halted}, {16'd1, 16'd1});
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
